mmc_rd_return_buf: RTL and testbench

- Per-channel read-return buffer between the DFI block's MMC-side return path and the MRC.
- Accepts read-data beats from DFI with no backpressure and checks burst framing, then buffers them and replays them to the MRC over a valid/ready interface.
- Issues read credits to the MMC so that the MMC never requests more read data than the buffer can hold.
- One instance per DRAM channel (`MGR_DRAM_NUM_CHANNELS` instances).

---
 rtl/mmc_rd_return_buf.sv | 151 +++++++++++++++
 tb/tb_mmc_rd_return_buf.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mmc_rd_return_buf.sv
// Purpose: per-channel read-return buffer; checks DFI burst framing, stores beats, replays them to the MRC and meters MMC read credits.
// Latency: a beat pushed in cycle N is presented in cycle N+1; back-to-back pops sustain 1 beat/cycle.
// Backpressure: none on the DFI input (full without pop drops and flags); MRC side is valid/ready with show-ahead head.
module mmc_rd_return_buf #(
  parameter int NUM_WORDS    = 8,
  parameter int BURST_BEATS  = 2,
  parameter int DEPTH_BURSTS = 4,
  localparam int DW          = NUM_WORDS * 32,
  localparam int DEPTH_BEATS = DEPTH_BURSTS * BURST_BEATS,
  localparam int OCC_W       = $clog2(DEPTH_BEATS + 1)
) (
  input  logic             clk,
  input  logic             reset_poweron_n,
  input  logic             dfi__rrb__valid,
  input  logic [1:0]       dfi__rrb__cntl,
  input  logic [DW-1:0]    dfi__rrb__data,
  input  logic             mmc__rrb__rd_issue,
  output logic             rrb__mmc__rd_credit_avail,
  output logic [OCC_W-1:0] rrb__mmc__occupancy,
  output logic [3:0]       rrb__mmc__err,
  output logic             rrb__mrc__valid,
  output logic [1:0]       rrb__mrc__cntl,
  output logic [DW-1:0]    rrb__mrc__data,
  input  logic             mrc__rrb__ready
);

  // Framing encoding: bit0 = start of message, bit1 = end of message
  // (MOM 2'b00, SOM 2'b01, EOM 2'b10, SOM_EOM 2'b11).
  localparam int PW = (DEPTH_BEATS > 1) ? $clog2(DEPTH_BEATS) : 1;
  localparam int BW = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;
  localparam int RW = $clog2(DEPTH_BURSTS + 1);

  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_IN_BURST = 1'b1;

  localparam logic [BW-1:0]    LAST_POS = BW'(BURST_BEATS - 1);
  localparam logic [PW-1:0]    LAST_PTR = PW'(DEPTH_BEATS - 1);
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH_BEATS);
  localparam logic [RW-1:0]    MAX_RES  = RW'(DEPTH_BURSTS);

  logic [0:0]       state;
  logic [BW-1:0]    bidx;
  logic [DW-1:0]    mem [DEPTH_BEATS];
  logic [BW-1:0]    tag [DEPTH_BEATS];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [OCC_W-1:0] occ;
  logic [RW-1:0]    reserved;
  logic [RW-1:0]    pending_rx;
  logic [3:0]       err;

  logic [BW-1:0] in_pos;
  logic [BW-1:0] head_pos;
  logic [1:0]    in_cntl_exp;
  logic          in_som;
  logic          pop;
  logic          full;
  logic          push;
  logic          drop;
  logic          res_dec;
  logic          issue_ok;
  logic          pend_dec;

  // Beat position comes from the FSM alone, so a bad cntl never shifts framing.
  assign in_pos      = (state == ST_IDLE) ? '0 : bidx;
  assign in_cntl_exp = {in_pos == LAST_POS, in_pos == '0};
  assign in_som      = dfi__rrb__valid && (state == ST_IDLE);

  assign head_pos = tag[rd_ptr];
  assign pop      = rrb__mrc__valid && mrc__rrb__ready;
  assign full     = (occ == FULL_OCC);
  assign push     = dfi__rrb__valid && (!full || pop);
  assign drop     = dfi__rrb__valid && full && !pop;

  // An EOM pop frees its slot in the same cycle, so a coincident issue is still honoured.
  assign res_dec  = pop && (head_pos == LAST_POS) && (reserved != '0);
  assign issue_ok = mmc__rrb__rd_issue && ((reserved != MAX_RES) || res_dec);
  assign pend_dec = in_som && (pending_rx != '0);

  assign rrb__mrc__valid           = (occ != '0);
  assign rrb__mrc__data            = rrb__mrc__valid ? mem[rd_ptr] : '0;
  assign rrb__mrc__cntl            = rrb__mrc__valid ? {head_pos == LAST_POS, head_pos == '0} : 2'b00;
  assign rrb__mmc__rd_credit_avail = (reserved < MAX_RES);
  assign rrb__mmc__occupancy       = occ;
  assign rrb__mmc__err             = err;

  // Input framing FSM: advance by position on every valid beat, flag cntl mismatches.
  always_ff @(posedge clk or negedge reset_poweron_n) begin
    if (!reset_poweron_n) begin
      state <= ST_IDLE;
      bidx  <= '0;
    end else if (dfi__rrb__valid) begin
      if (in_pos == LAST_POS) begin
        state <= ST_IDLE;
        bidx  <= '0;
      end else begin
        state <= ST_IN_BURST;
        bidx  <= in_pos + BW'(1);
      end
    end
  end

  // Beat and position-tag storage; unreset because outputs are gated by valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= dfi__rrb__data;
      tag[wr_ptr] <= in_pos;
    end
  end

  // Circular FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge reset_poweron_n) begin
    if (!reset_poweron_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
      if (pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);
      if (push && !pop)      occ <= occ + OCC_W'(1);
      else if (pop && !push) occ <= occ - OCC_W'(1);
    end
  end

  // Credit bookkeeping: reserved slots and bursts still owed on the input.
  always_ff @(posedge clk or negedge reset_poweron_n) begin
    if (!reset_poweron_n) begin
      reserved   <= '0;
      pending_rx <= '0;
    end else begin
      if (issue_ok && !res_dec)      reserved <= reserved + RW'(1);
      else if (!issue_ok && res_dec) reserved <= reserved - RW'(1);
      // pending_rx saturates so unsolicited traffic cannot wrap it
      if (issue_ok && !pend_dec && (pending_rx != '1)) pending_rx <= pending_rx + RW'(1);
      else if (!issue_ok && pend_dec)                  pending_rx <= pending_rx - RW'(1);
    end
  end

  // Sticky error flags.
  always_ff @(posedge clk or negedge reset_poweron_n) begin
    if (!reset_poweron_n) begin
      err <= '0;
    end else begin
      err <= err | {in_som && (pending_rx == '0),
                    mmc__rrb__rd_issue && !issue_ok,
                    dfi__rrb__valid && (dfi__rrb__cntl != in_cntl_exp),
                    drop};
    end
  end

endmodule

// File: tb/tb_mmc_rd_return_buf.sv
// Purpose: self-checking bench for mmc_rd_return_buf with a queue-based reference model and scoreboard.
// Latency: model expects a pushed beat visible one cycle later and 1 beat/cycle drain.
// Backpressure: MRC ready is driven from directed sequences and random patterns.
module tb_mmc_rd_return_buf;
  localparam int NW    = 8;
  localparam int BB    = 2;
  localparam int DB    = 4;
  localparam int DW    = NW * 32;
  localparam int DEPTH = DB * BB;
  localparam int OW    = $clog2(DEPTH + 1);

  localparam logic [1:0] C_MOM = 2'b00, C_SOM = 2'b01, C_EOM = 2'b10, C_SOM_EOM = 2'b11;

  typedef struct packed {
    logic [1:0]    cntl;
    logic [DW-1:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [1:0]    in_cntl;
  logic [DW-1:0] in_data;
  logic          rd_issue;
  logic          credit;
  logic [OW-1:0] occupancy;
  logic [3:0]    err;
  logic          out_valid;
  logic [1:0]    out_cntl;
  logic [DW-1:0] out_data;
  logic          ready;

  mmc_rd_return_buf #(.NUM_WORDS(NW), .BURST_BEATS(BB), .DEPTH_BURSTS(DB)) dut (
    .clk                       (clk),
    .reset_poweron_n           (rst_n),
    .dfi__rrb__valid           (in_valid),
    .dfi__rrb__cntl            (in_cntl),
    .dfi__rrb__data            (in_data),
    .mmc__rrb__rd_issue        (rd_issue),
    .rrb__mmc__rd_credit_avail (credit),
    .rrb__mmc__occupancy       (occupancy),
    .rrb__mmc__err             (err),
    .rrb__mrc__valid           (out_valid),
    .rrb__mrc__cntl            (out_cntl),
    .rrb__mrc__data            (out_data),
    .mrc__rrb__ready           (ready)
  );

  always #5 clk = ~clk;

  // Reference model state.
  int         mq[$];      // stored beat positions, head first
  exp_t       exp_q[$];   // scoreboard of expected output beats
  int         m_res, m_pend, m_beats;
  logic [3:0] m_err;
  int         passed = 0;
  int         total  = 0;
  exp_t       mon_e;

  function automatic logic [1:0] pos_cntl(input int pos);
    if (BB == 1)      return C_SOM_EOM;
    if (pos == 0)     return C_SOM;
    if (pos == BB-1)  return C_EOM;
    return C_MOM;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic model_clear();
    mq.delete();
    exp_q.delete();
    m_res = 0; m_pend = 0; m_beats = 0; m_err = 4'h0;
  endtask

  // Monitor: every handshake pops the scoreboard and compares.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid && ready) begin
      total++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_beat: got cntl %0d with empty scoreboard at %0t", out_cntl, $time);
      end else begin
        mon_e = exp_q.pop_front();
        if (out_cntl === mon_e.cntl && out_data === mon_e.data) passed++;
        else $display("FAIL out_beat: got cntl %0d data %h expected cntl %0d data %h",
                      out_cntl, out_data, mon_e.cntl, mon_e.data);
      end
    end
  end

  // One clock of stimulus; entered and left at posedge+1.
  task automatic cycle(input logic v, input logic [1:0] c, input logic [DW-1:0] d,
                       input logic iss, input logic rdy);
    int size_before, pos;
    bit pop, eom_pop, dec_ok;
    in_valid = v; in_cntl = c; in_data = d; rd_issue = iss; ready = rdy;
    size_before = mq.size();
    pop     = (size_before > 0) && rdy;
    eom_pop = pop && (mq[0] == BB-1);
    if (pop) void'(mq.pop_front());
    if (v) begin
      pos = m_beats % BB;
      if (c != pos_cntl(pos)) m_err[1] = 1'b1;
      if (pos == 0) begin
        if (m_pend == 0) m_err[3] = 1'b1;
        else m_pend--;
      end
      if (size_before < DEPTH || pop) begin
        mq.push_back(pos);
        exp_q.push_back({pos_cntl(pos), d});
      end else begin
        m_err[0] = 1'b1;
      end
      m_beats++;
    end
    dec_ok = eom_pop && (m_res > 0);
    if (iss) begin
      if (m_res < DB || dec_ok) begin m_res++; m_pend++; end
      else m_err[2] = 1'b1;
    end
    if (dec_ok) m_res--;
    @(posedge clk); #1;
    chk("occupancy", occupancy, mq.size());
    chk("credit_avail", credit, (m_res < DB) ? 1 : 0);
    chk("err", err, m_err);
    chk("out_valid", out_valid, (mq.size() != 0) ? 1 : 0);
  endtask

  task automatic idle(input logic rdy);
    cycle(1'b0, 2'b00, '0, 1'b0, rdy);
  endtask

  task automatic send_burst(input logic [DW-1:0] d0, input logic rdy);
    for (int i = 0; i < BB; i++) cycle(1'b1, pos_cntl(i), d0 ^ DW'(i), 1'b0, rdy);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_cntl"}, out_cntl, 0);
    chk({tag, "_data_nz"}, |out_data, 0);
    chk({tag, "_occupancy"}, occupancy, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_credit"}, credit, 1);
  endtask

  // Assert reset mid-cycle, check outputs fall immediately, release a cycle later.
  task automatic mid_reset(input string tag);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs(tag);
    in_valid = 1'b0; rd_issue = 1'b0; ready = 1'b0; in_cntl = 2'b00; in_data = '0;
    model_clear();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [DW-1:0] rd;
    logic [1:0]    c;
    logic          v, iss, rdy;
    int            to_send, cur_pos;
    rst_n = 1'b0; in_valid = 1'b0; in_cntl = 2'b00; in_data = '0; rd_issue = 1'b0; ready = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 check_reset_outputs("reset");
    rst_n = 1'b1;

    // Single burst with ready high.
    cycle(1'b0, 2'b00, '0, 1'b1, 1'b1);
    send_burst({32{8'hA5}}, 1'b1);
    repeat (2) idle(1'b1);

    // Fill with ready low, credit exhaustion, then a 5th issue.
    for (int i = 0; i < DB; i++) cycle(1'b0, 2'b00, '0, 1'b1, 1'b0);
    chk("credit_low_after_fill", credit, 0);
    for (int i = 0; i < DB; i++) send_burst({8{$urandom}}, 1'b0);
    chk("occupancy_full", occupancy, DEPTH);
    cycle(1'b0, 2'b00, '0, 1'b1, 1'b0);
    chk("err2_on_extra_issue", err[2], 1);

    // Drain with an issue on the first EOM pop: reserved stays at DB.
    idle(1'b1);
    cycle(1'b0, 2'b00, '0, 1'b1, 1'b1);
    chk("credit_held_on_issue_with_eom_pop", credit, 0);
    repeat (DEPTH - 2) idle(1'b1);
    chk("drained_after_full", exp_q.size(), 0);
    send_burst({8{$urandom}}, 1'b1);
    repeat (2) idle(1'b1);

    // Overflow: DEPTH+1 beats, no issues, ready low.
    mid_reset("rst_a");
    for (int i = 0; i <= DEPTH; i++) cycle(1'b1, pos_cntl(i % BB), {8{$urandom}}, 1'b0, 1'b0);
    chk("overflow_err0", err[0], 1);
    chk("overflow_err3", err[3], 1);
    repeat (DEPTH + 1) idle(1'b1);
    chk("overflow_drained", exp_q.size(), 0);

    // Framing error burst, then a clean burst.
    mid_reset("rst_b");
    cycle(1'b0, 2'b00, '0, 1'b1, 1'b1);
    for (int i = 0; i < BB; i++) cycle(1'b1, C_MOM, {8{$urandom}}, 1'b0, 1'b1);
    chk("framing_err1", err[1], 1);
    cycle(1'b0, 2'b00, '0, 1'b1, 1'b1);
    send_burst({8{$urandom}}, 1'b1);
    repeat (2) idle(1'b1);
    chk("framing_only_err1", err, 4'b0010);

    // Reset after the SOM beat; a new burst after release starts clean.
    mid_reset("rst_c");
    cycle(1'b0, 2'b00, '0, 1'b1, 1'b0);
    cycle(1'b1, C_SOM, {8{$urandom}}, 1'b0, 1'b0);
    mid_reset("rst_mid");
    cycle(1'b0, 2'b00, '0, 1'b1, 1'b1);
    send_burst({8{$urandom}}, 1'b1);
    repeat (2) idle(1'b1);

    // Random traffic obeying credits, with occasional corrupted framing.
    mid_reset("rst_d");
    to_send = 0; cur_pos = 0;
    for (int n = 0; n < 3000; n++) begin
      iss = (m_res < DB) && ($urandom_range(0, 3) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      v   = ((cur_pos != 0) || (to_send > 0)) && ($urandom_range(0, 1) == 1);
      c   = pos_cntl(cur_pos);
      if ($urandom_range(0, 49) == 0) c = 2'($urandom_range(0, 3));
      rd  = {8{$urandom}};
      if (v) begin
        if (cur_pos == 0) to_send--;
        cur_pos = (cur_pos + 1) % BB;
      end
      if (iss) to_send++;
      cycle(v, c, rd, iss, rdy);
    end
    repeat (DEPTH + 4) idle(1'b1);
    chk("random_drained", exp_q.size(), 0);
    chk("random_no_overflow", err[0], 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
